// File: rtl/clock_pkg.sv
// Shared definitions for the run/halt/step clock controller.
package clock_pkg;

  localparam int unsigned DEFAULT_HALF_PERIOD = 130000;

  localparam logic [1:0] CMD_HALT    = 2'b00;
  localparam logic [1:0] CMD_RUN     = 2'b01;
  localparam logic [1:0] CMD_STEP    = 2'b10;
  localparam logic [1:0] CMD_SET_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'b00,
    ST_RUN      = 2'b01,
    ST_STEP     = 2'b10,
    ST_STOPPING = 2'b11
  } state_t;

endpackage

// File: rtl/clock_divider.sv
// Half-period divider producing a glitch-free o_clk that can be forced low only between phases.
module clock_divider #(
  parameter int unsigned DIV_WIDTH = 24
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_clr,
  input  logic [DIV_WIDTH-1:0] i_half_period,
  output logic                 o_clk,
  output logic                 o_tick,
  output logic                 o_rise_c,
  output logic                 o_fall_c
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic                 hit_c;

  // Last cycle of the current phase; half_period is never 0 here.
  assign hit_c    = i_en && (cnt_q == (i_half_period - DIV_WIDTH'(1)));
  assign o_rise_c = hit_c && !o_clk;
  assign o_fall_c = hit_c && o_clk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      o_clk  <= 1'b0;
      o_tick <= 1'b0;
    end else if (i_clr || !i_en) begin
      cnt_q  <= '0;
      o_clk  <= 1'b0;
      o_tick <= 1'b0;
    end else if (hit_c) begin
      cnt_q  <= '0;
      o_clk  <= !o_clk;
      o_tick <= !o_clk;
    end else begin
      cnt_q  <= cnt_q + DIV_WIDTH'(1);
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_run_ctrl.sv
// Run/halt/step controller: command handshake, step counter and FSM around the CPU clock divider.
module clock_run_ctrl #(
  parameter int unsigned DIV_WIDTH           = 24,
  parameter int unsigned DEFAULT_HALF_PERIOD = clock_pkg::DEFAULT_HALF_PERIOD,
  parameter int unsigned STEP_WIDTH          = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd,
  input  logic [DIV_WIDTH-1:0]  i_cmd_arg,
  input  logic                  i_cpu_halt,
  output logic                  o_clk,
  output logic                  o_tick,
  output logic [1:0]            o_state,
  output logic [STEP_WIDTH-1:0] o_steps_left
);
  import clock_pkg::*;

  state_t                state_q;
  logic [DIV_WIDTH-1:0]  half_period_q;
  logic [STEP_WIDTH-1:0] steps_q;

  logic                  accept_c;
  logic                  halt_req_c;
  logic                  last_step_c;
  logic                  stop_c;
  logic                  div_en_c;
  logic                  div_clr_c;
  logic                  rise_c;
  logic                  fall_c;
  logic [STEP_WIDTH-1:0] step_arg_c;
  logic [DIV_WIDTH-1:0]  div_arg_c;

  // Stop decisions; the final-step rising toggle wins over any halt request.
  always_comb begin
    accept_c    = i_cmd_valid && (state_q != ST_STOPPING);
    halt_req_c  = i_cpu_halt || (accept_c && (i_cmd == CMD_HALT));
    last_step_c = (state_q == ST_STEP) && rise_c && (steps_q == STEP_WIDTH'(1));
    stop_c      = halt_req_c && !last_step_c &&
                  ((state_q == ST_RUN) || (state_q == ST_STEP));
    div_en_c    = (state_q != ST_HALTED);
    div_clr_c   = stop_c && !o_clk;
    step_arg_c  = (i_cmd_arg[STEP_WIDTH-1:0] == '0) ? STEP_WIDTH'(1)
                                                    : i_cmd_arg[STEP_WIDTH-1:0];
    div_arg_c   = (i_cmd_arg == '0) ? DIV_WIDTH'(1) : i_cmd_arg;
  end

  clock_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_div (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (div_en_c),
    .i_clr        (div_clr_c),
    .i_half_period(half_period_q),
    .o_clk        (o_clk),
    .o_tick       (o_tick),
    .o_rise_c     (rise_c),
    .o_fall_c     (fall_c)
  );

  // A stop with o_clk high waits out the high phase, unless it is ending this very cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_HALTED;
      half_period_q <= DIV_WIDTH'(DEFAULT_HALF_PERIOD);
      steps_q       <= '0;
    end else begin
      case (state_q)
        ST_HALTED: begin
          if (accept_c) begin
            case (i_cmd)
              CMD_RUN:     if (!i_cpu_halt) state_q <= ST_RUN;
              CMD_STEP: begin
                if (!i_cpu_halt) begin
                  state_q <= ST_STEP;
                  steps_q <= step_arg_c;
                end
              end
              CMD_SET_DIV: half_period_q <= div_arg_c;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (stop_c) begin
            state_q <= (o_clk && !fall_c) ? ST_STOPPING : ST_HALTED;
          end else if (accept_c && (i_cmd == CMD_STEP)) begin
            state_q <= ST_STEP;
            steps_q <= step_arg_c;
          end
        end
        ST_STEP: begin
          if (last_step_c) begin
            state_q <= ST_STOPPING;
            steps_q <= '0;
          end else if (stop_c) begin
            state_q <= (o_clk && !fall_c) ? ST_STOPPING : ST_HALTED;
            steps_q <= '0;
          end else if (accept_c && (i_cmd == CMD_RUN)) begin
            state_q <= ST_RUN;
            steps_q <= '0;
          end else if (rise_c) begin
            steps_q <= steps_q - STEP_WIDTH'(1);
          end
        end
        ST_STOPPING: begin
          if (fall_c) state_q <= ST_HALTED;
        end
        default: state_q <= ST_HALTED;
      endcase
    end
  end

  assign o_cmd_ready  = (state_q != ST_STOPPING);
  assign o_state      = state_q;
  assign o_steps_left = steps_q;

endmodule

// File: tb/tb_clock_run_ctrl.sv
// Scoreboard bench for clock_run_ctrl: phase-based reference model plus directed timing checks.
module tb_clock_run_ctrl;

  localparam int unsigned DW = 24;
  localparam int unsigned SW = 16;
  localparam int unsigned HP = 4;

  localparam logic [1:0] C_HALT = 2'b00;
  localparam logic [1:0] C_RUN  = 2'b01;
  localparam logic [1:0] C_STEP = 2'b10;
  localparam logic [1:0] C_DIV  = 2'b11;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd       = 2'b00;
  logic [DW-1:0] cmd_arg   = '0;
  logic          cpu_halt  = 1'b0;
  logic          cmd_ready;
  logic          cpu_clk;
  logic          tick;
  logic [1:0]    state;
  logic [SW-1:0] steps_left;

  clock_run_ctrl #(
    .DIV_WIDTH(DW),
    .DEFAULT_HALF_PERIOD(HP),
    .STEP_WIDTH(SW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd       (cmd),
    .i_cmd_arg   (cmd_arg),
    .i_cpu_halt  (cpu_halt),
    .o_clk       (cpu_clk),
    .o_tick      (tick),
    .o_state     (state),
    .o_steps_left(steps_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int ck;
    int tk;
    int steps;
    int rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   tick_total = 0;

  // Reference: mode 0 halted, 1 run, 2 step, 3 stopping; clock tracked as level + age within phase.
  int m_mode, m_level, m_tick, m_age, m_hp, m_steps;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_level = 0; m_tick = 0; m_age = 0; m_hp = HP; m_steps = 0;
  endtask

  task automatic model_step(input int v, input int c, input int unsigned a, input int h);
    int acc, phase_end, rising, falling, halt_rq, kill, nmode, nsteps;
    acc       = v && (m_mode != 3);
    phase_end = (m_mode != 0) && (m_age + 1 == m_hp);
    rising    = phase_end && (m_level == 0);
    falling   = phase_end && (m_level == 1);
    halt_rq   = h || (acc && c == 0);
    nmode     = m_mode;
    nsteps    = m_steps;
    kill      = 0;
    case (m_mode)
      0: begin
        if (acc && !h && c == 1) nmode = 1;
        else if (acc && !h && c == 2) begin
          nmode  = 2;
          nsteps = ((a % 65536) == 0) ? 1 : int'(a % 65536);
        end else if (acc && c == 3) m_hp = (a == 0) ? 1 : int'(a);
      end
      1: begin
        if (halt_rq) begin
          nmode = (m_level == 1 && !falling) ? 3 : 0;
          kill  = (m_level == 0);
        end else if (acc && c == 2) begin
          nmode  = 2;
          nsteps = ((a % 65536) == 0) ? 1 : int'(a % 65536);
        end
      end
      2: begin
        if (rising && m_steps == 1) begin
          nmode = 3; nsteps = 0;
        end else if (halt_rq) begin
          nmode  = (m_level == 1 && !falling) ? 3 : 0;
          kill   = (m_level == 0);
          nsteps = 0;
        end else if (acc && c == 1) begin
          nmode = 1; nsteps = 0;
        end else if (rising) nsteps = m_steps - 1;
      end
      default: if (falling) nmode = 0;
    endcase
    if (m_mode == 0 || kill) begin
      m_age = 0; m_level = 0; m_tick = 0;
    end else if (phase_end) begin
      m_age = 0; m_level = 1 - m_level; m_tick = m_level;
    end else begin
      m_age = m_age + 1; m_tick = 0;
    end
    m_mode  = nmode;
    m_steps = nsteps;
  endtask

  // Model advances on every edge and queues what the DUT must show after it.
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step(int'(cmd_valid), int'(cmd), int'(cmd_arg), int'(cpu_halt));
    exp_q.push_back('{m_mode, m_level, m_tick, m_steps, (m_mode != 3) ? 1 : 0});
  end

  always @(negedge clk) begin
    if (tick) tick_total++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("sb_state", int'(state), mon_e.st);
      check("sb_clk", int'(cpu_clk), mon_e.ck);
      check("sb_tick", int'(tick), mon_e.tk);
      check("sb_steps", int'(steps_left), mon_e.steps);
      check("sb_ready", int'(cmd_ready), mon_e.rdy);
    end
  end

  task automatic step_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] c, input int unsigned a);
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_arg   = DW'(a);
    step_cycles(1);
    cmd_valid = 1'b0;
  endtask

  // what: 0 tick, 1 o_clk low, 2 halted, 3 stopping, 4 o_clk high
  task automatic wait_for(input int what, input int limit, output int n);
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      step_cycles(1);
      n++;
      case (what)
        0:       done = tick;
        1:       done = !cpu_clk;
        2:       done = (state == 2'b00);
        3:       done = (state == 2'b11);
        default: done = cpu_clk;
      endcase
      if (!done && n >= limit) begin
        n_cmp++;
        n_err++;
        $display("FAIL wait_%0d: timed out after %0d cycles, event required", what, n);
        done = 1'b1;
      end
    end
  endtask

  initial begin
    int n;
    int t0;
    #12 rst_n = 1'b1;
    step_cycles(1);

    // RUN: first tick latency, period, then HALT one cycle into a high phase
    send(C_RUN, 0);
    check("run_state", int'(state), 1);
    wait_for(0, 40, n);
    check("run_first_tick", n, 4);
    wait_for(0, 40, n);
    check("run_period", n, 8);
    send(C_HALT, 0);
    check("halt_stopping", int'(state), 3);
    check("halt_ready", int'(cmd_ready), 0);
    wait_for(1, 40, n);
    check("halt_high_left", n, 3);
    check("halt_done", int'(state), 0);

    // STEP 3 from HALTED
    t0 = tick_total;
    send(C_STEP, 3);
    check("step_state", int'(state), 2);
    check("step_load", int'(steps_left), 3);
    wait_for(3, 100, n);
    wait_for(2, 40, n);
    check("step_final_high", n, 4);
    check("step_clk_low", int'(cpu_clk), 0);
    step_cycles(1);
    check("step_ticks", tick_total - t0, 3);

    // SET_DIV 0 gives i_clk/2; SET_DIV during RUN is ignored
    send(C_DIV, 0);
    send(C_RUN, 0);
    wait_for(0, 10, n);
    wait_for(0, 10, n);
    check("div0_period", n, 2);
    send(C_DIV, 10);
    wait_for(0, 10, n);
    wait_for(0, 30, n);
    check("div_ignored", n, 2);
    send(C_HALT, 0);
    wait_for(2, 10, n);

    // CPU halt beats RUN; CPU halt during RUN with o_clk low
    t0 = tick_total;
    cpu_halt = 1'b1;
    send(C_RUN, 0);
    cpu_halt = 1'b0;
    step_cycles(3);
    check("cpuhalt_beats_run", int'(state), 0);
    check("cpuhalt_no_tick", tick_total - t0, 0);
    send(C_RUN, 0);
    wait_for(0, 10, n);
    step_cycles(1);
    cpu_halt = 1'b1;
    step_cycles(1);
    cpu_halt = 1'b0;
    check("cpuhalt_run_state", int'(state), 0);
    check("cpuhalt_run_clk", int'(cpu_clk), 0);

    // Randomised traffic against the scoreboard
    send(C_DIV, 3);
    for (int i = 0; i < 600; i++) begin
      cpu_halt = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b1;
        cmd       = 2'($urandom_range(0, 3));
        cmd_arg   = DW'($urandom_range(0, 4));
      end else begin
        cmd_valid = 1'b0;
      end
      step_cycles(1);
    end
    cmd_valid = 1'b0;
    cpu_halt  = 1'b0;
    send(C_HALT, 0);
    wait_for(2, 60, n);

    // Asynchronous reset in the middle of a STEP high phase
    send(C_DIV, 6);
    send(C_STEP, 5);
    wait_for(4, 60, n);
    step_cycles(1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_clk", int'(cpu_clk), 0);
    check("rst_state", int'(state), 0);
    check("rst_steps", int'(steps_left), 0);
    check("rst_ready", int'(cmd_ready), 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step_cycles(1);
    send(C_RUN, 0);
    wait_for(0, 40, n);
    check("rst_default_div", n, 4);
    send(C_HALT, 0);
    wait_for(2, 40, n);
    step_cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
